// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit that owns the HI/LO registers.
// Optional MADD/MADDU accumulate ops are built only when MDU_MADD_EN is defined.
module mdu_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d, done_q, done_d;
`ifdef MDU_MADD_EN
  logic        madd_q, madd_d;
`endif

  logic        op_ok, in_sgn, mul_last, q_bit;
  logic [63:0] mul_a, mul_b, product;
  logic [32:0] rem_shift, diff;
  logic [31:0] new_rem, new_quo, quo_fix, rem_fix;

  always_comb begin
    in_sgn = ~op[0];
`ifdef MDU_MADD_EN
    op_ok = ~(op[2] & op[1]);
`else
    op_ok = ~op[2];
`endif
    mul_a   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    mul_b   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    product = mul_a * mul_b;

    // One restoring step: divide magnitudes, signs are applied on the last step.
    rem_shift = {rem_q, quo_q[31]};
    diff      = rem_shift - {1'b0, dvs_q};
    q_bit     = ~diff[32];
    new_rem   = q_bit ? diff[31:0] : rem_shift[31:0];
    new_quo   = {quo_q[30:0], q_bit};
    quo_fix   = (sgn_q & (a_q[31] ^ b_q[31])) ? -new_quo : new_quo;
    rem_fix   = (sgn_q & a_q[31]) ? -new_rem : new_rem;

`ifdef MDU_MADD_EN
    mul_last = (cnt_q == (madd_q ? MUL_LAST + 6'd1 : MUL_LAST));
`else
    mul_last = (cnt_q == MUL_LAST);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MDU_MADD_EN
    madd_d  = madd_q;
`endif

    case (state_q)
      IDLE: begin
        if (start && !flush && op_ok) begin
          state_d = op[1] ? DIV : MUL;
          cnt_d   = 6'd0;
          sgn_d   = in_sgn;
          a_d     = A;
          b_d     = B;
          rem_d   = 32'd0;
          quo_d   = (in_sgn & A[31]) ? -A : A;
          dvs_d   = (in_sgn & B[31]) ? -B : B;
          busy_d  = 1'b1;
`ifdef MDU_MADD_EN
          madd_d  = op[2];
`endif
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      MUL: begin
        // The completion edge retires the op even if a flush arrives with it.
        if (mul_last) begin
          {hi_d, lo_d} = product;
`ifdef MDU_MADD_EN
          if (madd_q) {hi_d, lo_d} = {hi_q, lo_q} + product;
`endif
          state_d = IDLE;
          cnt_d   = 6'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (flush) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      DIV: begin
        if (cnt_q == DIV_LAST) begin
          if (b_q == 32'd0) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
          state_d = IDLE;
          cnt_d   = 6'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (flush) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
          busy_d  = 1'b0;
        end else begin
          rem_d = new_rem;
          quo_d = new_quo;
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      sgn_q   <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MDU_MADD_EN
      madd_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MDU_MADD_EN
      madd_q  <= madd_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: vector table, random scoreboarded ops and
// hand-written flush/reset/write-ignore sequences; MADD checks follow MDU_MADD_EN.
module tb_mdu_unit;

  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 32;

  logic        clk = 1'b0;
  logic        rstn, start, flush, hi_we, lo_we;
  logic [2:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  mdu_unit #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .A(a), .B(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t        vecs[14];
  logic [63:0] sb_q[$];
  int          passed = 0;
  int          total  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Called at a negedge; drives start for one cycle and returns at the negedge
  // where busy has dropped, so consecutive calls run back-to-back.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                               input int exp_cycles, input string name);
    int          cycles;
    logic [63:0] exp;
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    sb_q.push_back({exp_hi, exp_lo});
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    checkOutput({name, " done low in flight"}, {31'b0, done}, 32'd0);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    checkOutput({name, " latency"}, 32'(cycles), 32'(exp_cycles));
    checkOutput({name, " done pulse"}, {31'b0, done}, 32'd1);
    if (sb_q.size() == 0) begin
      total++;
      $display("[TB] FAIL %s scoreboard: got empty queue expected an entry", name);
    end else begin
      exp = sb_q.pop_front();
      checkOutput({name, " hi"}, hi, exp[63:32]);
      checkOutput({name, " lo"}, lo, exp[31:0]);
    end
  endtask

  task automatic waitIdle(input string name);
    int cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    checkOutput({name, " completes"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          seen;
    int          sa, sb;
    logic [31:0] av, bv;
    logic [63:0] p64;
    logic [2:0]  ro;

    vecs[0]  = '{3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{3'b001, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1};
    vecs[2]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[4]  = '{3'b000, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[5]  = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6]  = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[7]  = '{3'b010, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
    vecs[8]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[9]  = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[10] = '{3'b011, 32'hFFFFFFFF, 32'd2,        32'd1,        32'h7FFFFFFF};
    vecs[11] = '{3'b010, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2};
    vecs[12] = '{3'b011, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
    vecs[13] = '{3'b010, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};

    rstn = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 3'b000; a = 32'd0; b = 32'd0; wdata = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++)
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                    vecs[i].op[1] ? DIV_CYCLES : MUL_CYCLES, $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      av = $urandom;
      bv = $urandom;
      ro = 3'($urandom_range(0, 3));
      case (ro)
        3'b000: begin sa = av; sb = bv; p64 = 64'(longint'(sa) * longint'(sb)); end
        3'b001: p64 = {32'b0, av} * {32'b0, bv};
        3'b011: begin
          if (bv == 32'd0) bv = 32'd3;
          p64 = {av % bv, av / bv};
        end
        default: begin
          sa = av; sb = bv;
          if (sb == 0) sb = 5;
          if (sa == 32'sh80000000) sa = sa + 1;
          av = sa; bv = sb;
          p64 = {32'(sa % sb), 32'(sa / sb)};
        end
      endcase
      applyStimulus(ro, av, bv, p64[63:32], p64[31:0],
                    ro[1] ? DIV_CYCLES : MUL_CYCLES, $sformatf("rand%0d", i));
    end

    // mthi preload, then flush a DIVU at cycle 10
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000AAAA;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    checkOutput("mthi preload", hi, 32'h0000AAAA);
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    checkOutput("flush busy before", {31'b0, busy}, 32'd1);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush busy after", {31'b0, busy}, 32'd0);
    checkOutput("flush hi kept", hi, 32'h0000AAAA);
    checkOutput("flush lo kept", lo, 32'h0000AAAA);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checkOutput("flush no done", 32'(seen), 32'd0);
    checkOutput("flush hi later", hi, 32'h0000AAAA);

    // async reset in the middle of a divide
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    checkOutput("midreset hi", hi, 32'd0);
    checkOutput("midreset lo", lo, 32'd0);
    checkOutput("midreset busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("midreset no result lo", lo, 32'd0);

    // mtlo/mthi and a second start while busy are ignored
    start = 1'b1; op = 3'b001; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    lo_we = 1'b1; hi_we = 1'b1; wdata = 32'h00000055;
    @(negedge clk);
    lo_we = 1'b0; hi_we = 1'b0;
    checkOutput("mtlo busy mid-op", lo, 32'd0);
    start = 1'b1; op = 3'b011; a = 32'd9; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    waitIdle("mtlo busy");
    checkOutput("mtlo busy done", {31'b0, done}, 32'd1);
    checkOutput("mtlo busy lo", lo, 32'd12);
    checkOutput("mtlo busy hi", hi, 32'd0);
    @(negedge clk);
    checkOutput("start while busy dropped", {31'b0, busy}, 32'd0);

    // flush in the completion cycle still retires the multiply
    start = 1'b1; op = 3'b000; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (MUL_CYCLES - 1) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("late flush lo", lo, 32'd42);
    checkOutput("late flush done", {31'b0, done}, 32'd1);
    checkOutput("late flush busy", {31'b0, busy}, 32'd0);

    // start together with flush is not accepted
    start = 1'b1; flush = 1'b1; op = 3'b001; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checkOutput("start+flush busy", {31'b0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    checkOutput("start+flush lo", lo, 32'd42);

    // start wins over a same-cycle mthi
    start = 1'b1; hi_we = 1'b1; wdata = 32'h0000BEEF; op = 3'b001; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    checkOutput("start+mthi hi", hi, 32'd0);
    waitIdle("start+mthi");
    checkOutput("start+mthi lo", lo, 32'd6);

    // reserved ops never start
    for (int r = 6; r < 8; r++) begin
      start = 1'b1; op = 3'(r); a = 32'd1; b = 32'd1;
      @(negedge clk);
      start = 1'b0;
      checkOutput($sformatf("reserved op%0d busy", r), {31'b0, busy}, 32'd0);
    end
    repeat (6) @(negedge clk);
    checkOutput("reserved lo kept", lo, 32'd6);

    // MADDU accumulate
    hi_we = 1'b1; wdata = 32'd0;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    lo_we = 1'b0;
`ifdef MDU_MADD_EN
    applyStimulus(3'b101, 32'd1, 32'd1, 32'd1, 32'd0, MUL_CYCLES + 1, "maddu");
    applyStimulus(3'b100, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, MUL_CYCLES + 1, "madd");
`else
    start = 1'b1; op = 3'b101; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("maddu off busy", {31'b0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    checkOutput("maddu off hi", hi, 32'd0);
    checkOutput("maddu off lo", lo, 32'hFFFFFFFF);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
